// File: rtl/color_apply_seq_pkg.sv
// Shared types for the color apply sequencer: FSM state encoding, the
// queued declaration record and a saturating counter helper.
package color_apply_seq_pkg;

  // Sequencer states; REG and VIS are the two resolver passes.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REG  = 2'd1,
    ST_VIS  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

  // One queued color declaration (46 bits).
  typedef struct packed {
    logic        is_ident;
    logic [9:0]  ident;
    logic [31:0] rgb;
    logic        regular;
    logic        visited;
    logic        last;
  } decl_t;

  localparam int unsigned DECL_W = $bits(decl_t);

  localparam logic [7:0] CNT_MAX = 8'hFF;

  // Increment that sticks at the counter ceiling instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == CNT_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/color_apply_seq_decl_fifo.sv
// Declaration FIFO: DEPTH entries of decl_t, registered read/write
// pointers with a wrap bit so full and empty are distinguishable.
module decl_fifo
  import color_apply_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  decl_t push_data,
  input  logic  pop,
  output decl_t head,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  decl_t       mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Pointers equal means empty; equal index with differing wrap bit means full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A full FIFO refuses the push even if the same cycle pops.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head = mem[rd_ptr[AW-1:0]];

  // Storage is cleared on reset so the head never carries stale data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Pointer update; reset discards everything queued.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/color_apply_seq.sv
// Color apply sequencer: drains queued declarations through one shared
// resolver, one pass for the regular style and one for the visited-link
// style, resolving currentcolor locally from the parent color and
// counting the writes applied per element.
module color_apply_seq
  import color_apply_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        decl_valid,
  output logic        decl_ready,
  input  logic        decl_is_ident,
  input  logic [9:0]  decl_ident,
  input  logic [31:0] decl_rgb,
  input  logic        decl_regular,
  input  logic        decl_visited,
  input  logic        decl_last,
  input  logic [9:0]  css_currentcolor,
  input  logic [31:0] parent_color,
  input  logic        parent_color_isvalid,
  input  logic [31:0] parent_invalid_color,
  output logic        res_is_ident,
  output logic [9:0]  res_ident,
  output logic [31:0] res_rgb,
  output logic        res_for_visited,
  input  logic [31:0] res_color,
  input  logic        hold,
  output logic        color_ld_en,
  output logic        visited_ld_en,
  output logic [31:0] color_data,
  output logic        elem_done,
  output logic [7:0]  applied_cnt
);

  seq_state_t  state;
  logic [7:0]  cnt;
  decl_t       in_decl;
  decl_t       head;
  logic        full;
  logic        empty;
  logic        pop;
  logic        pass_active;
  logic        writing;
  logic        inherit;
  logic [31:0] parent_value;
  logic [31:0] write_value;

  assign in_decl = '{
    is_ident: decl_is_ident,
    ident:    decl_ident,
    rgb:      decl_rgb,
    regular:  decl_regular,
    visited:  decl_visited,
    last:     decl_last
  };

  // Pushes stay open during hold; only the drain side stalls.
  assign decl_ready = !full;

  decl_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (decl_valid),
    .push_data(in_decl),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  // Write strobes follow the state directly so a stall gates them the same cycle.
  assign color_ld_en   = (state == ST_REG) && !hold;
  assign visited_ld_en = (state == ST_VIS) && !hold;
  assign elem_done     = (state == ST_DONE) && !hold;
  assign writing       = color_ld_en || visited_ld_en;
  assign applied_cnt   = cnt;

  // Resolver operands are only presented during a pass, zero otherwise.
  assign pass_active     = (state == ST_REG) || (state == ST_VIS);
  assign res_is_ident    = pass_active && head.is_ident;
  assign res_ident       = pass_active ? head.ident : '0;
  assign res_rgb         = pass_active ? head.rgb : '0;
  assign res_for_visited = (state == ST_VIS);

  // currentcolor never reaches the resolver result; it takes the parent color.
  assign inherit      = head.is_ident && (head.ident == css_currentcolor);
  assign parent_value = parent_color_isvalid ? parent_color : parent_invalid_color;
  assign write_value  = inherit ? parent_value : res_color;
  assign color_data   = writing ? write_value : '0;

  // Head is retired after its final pass, or straight from IDLE if it applies nowhere.
  always_comb begin
    pop = 1'b0;
    if (!hold) begin
      case (state)
        ST_IDLE: pop = !empty && !head.regular && !head.visited;
        ST_REG:  pop = !head.visited;
        ST_VIS:  pop = 1'b1;
        default: pop = 1'b0;
      endcase
    end
  end

  // Sequencer state and per-element write counter, both frozen by hold.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (!hold) begin
      if (writing) begin
        cnt <= sat_inc(cnt);
      end
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            if (head.regular) begin
              state <= ST_REG;
            end else if (head.visited) begin
              state <= ST_VIS;
            end else if (head.last) begin
              state <= ST_DONE;
            end
          end
        end
        ST_REG: begin
          if (head.visited) begin
            state <= ST_VIS;
          end else if (head.last) begin
            state <= ST_DONE;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_VIS: begin
          state <= head.last ? ST_DONE : ST_IDLE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_color_apply_seq.sv
// Testbench for color_apply_seq: directed timing scenarios plus a
// randomized run checked against an ordered list of expected writes.
module tb_color_apply_seq;

  localparam logic [9:0] CURRENTCOLOR_ID = 10'd201;
  localparam logic [9:0] RED_ID          = 10'd117;
  localparam logic [1:0] EV_COLOR        = 2'd1;
  localparam logic [1:0] EV_VISITED      = 2'd2;
  localparam logic [1:0] EV_DONE         = 2'd3;
  localparam int         RANDOM_DECLS    = 80;

  typedef struct packed {
    logic        is_ident;
    logic [9:0]  ident;
    logic [31:0] rgb;
    logic        regular;
    logic        visited;
    logic        last;
  } tb_decl_t;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] data;
    logic [7:0]  cnt;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        decl_valid;
  logic        decl_ready;
  logic        decl_is_ident;
  logic [9:0]  decl_ident;
  logic [31:0] decl_rgb;
  logic        decl_regular;
  logic        decl_visited;
  logic        decl_last;
  logic [9:0]  css_currentcolor;
  logic [31:0] parent_color;
  logic        parent_color_isvalid;
  logic [31:0] parent_invalid_color;
  logic        res_is_ident;
  logic [9:0]  res_ident;
  logic [31:0] res_rgb;
  logic        res_for_visited;
  logic [31:0] res_color;
  logic        hold;
  logic        color_ld_en;
  logic        visited_ld_en;
  logic [31:0] color_data;
  logic        elem_done;
  logic [7:0]  applied_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  ev_t ev_q[$];
  int  model_cnt = 0;

  always #5 clk = ~clk;

  // Stand-in for the shared resolver: Red maps to opaque red, other idents
  // to a tagged pattern, RGB passes through (byte-rotated for the visited pass).
  function automatic logic [31:0] resolve_model(input logic is_id, input logic [9:0] id,
                                                input logic [31:0] rgb, input logic vis);
    if (is_id) begin
      if (id == RED_ID) return 32'hFF0000FF;
      return {id, 5'd0, vis, 16'h5A3C};
    end
    return vis ? {rgb[7:0], rgb[31:8]} : rgb;
  endfunction

  assign res_color = resolve_model(res_is_ident, res_ident, res_rgb, res_for_visited);

  color_apply_seq #(.DEPTH(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .decl_valid          (decl_valid),
    .decl_ready          (decl_ready),
    .decl_is_ident       (decl_is_ident),
    .decl_ident          (decl_ident),
    .decl_rgb            (decl_rgb),
    .decl_regular        (decl_regular),
    .decl_visited        (decl_visited),
    .decl_last           (decl_last),
    .css_currentcolor    (css_currentcolor),
    .parent_color        (parent_color),
    .parent_color_isvalid(parent_color_isvalid),
    .parent_invalid_color(parent_invalid_color),
    .res_is_ident        (res_is_ident),
    .res_ident           (res_ident),
    .res_rgb             (res_rgb),
    .res_for_visited     (res_for_visited),
    .res_color           (res_color),
    .hold                (hold),
    .color_ld_en         (color_ld_en),
    .visited_ld_en       (visited_ld_en),
    .color_data          (color_data),
    .elem_done           (elem_done),
    .applied_cnt         (applied_cnt)
  );

  function automatic tb_decl_t make_decl(input logic is_id, input logic [9:0] id,
                                         input logic [31:0] rgb, input logic regular,
                                         input logic visited, input logic last);
    tb_decl_t d;
    d.is_ident = is_id;
    d.ident    = id;
    d.rgb      = rgb;
    d.regular  = regular;
    d.visited  = visited;
    d.last     = last;
    return d;
  endfunction

  // Value a pass should write for a declaration under the current parent inputs.
  function automatic logic [31:0] expected_write(input tb_decl_t d, input logic vis);
    if (d.is_ident && d.ident == CURRENTCOLOR_ID)
      return parent_color_isvalid ? parent_color : parent_invalid_color;
    return resolve_model(d.is_ident, d.ident, d.rgb, vis);
  endfunction

  // Appends the writes and completion a declaration will cause, in order.
  function automatic void model_add(input tb_decl_t d);
    ev_t e;
    if (d.regular) begin
      e = '{kind: EV_COLOR, data: expected_write(d, 1'b0), cnt: 8'd0};
      ev_q.push_back(e);
      model_cnt++;
    end
    if (d.visited) begin
      e = '{kind: EV_VISITED, data: expected_write(d, 1'b1), cnt: 8'd0};
      ev_q.push_back(e);
      model_cnt++;
    end
    if (d.last) begin
      e = '{kind: EV_DONE, data: 32'd0, cnt: (model_cnt > 255) ? 8'd255 : 8'(model_cnt)};
      ev_q.push_back(e);
      model_cnt = 0;
    end
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_decl(input tb_decl_t d);
    decl_valid    = 1'b1;
    decl_is_ident = d.is_ident;
    decl_ident    = d.ident;
    decl_rgb      = d.rgb;
    decl_regular  = d.regular;
    decl_visited  = d.visited;
    decl_last     = d.last;
  endtask

  // Offers one declaration for a single edge; returns in the following cycle.
  task automatic push_one(input tb_decl_t d);
    drive_decl(d);
    next_cycle();
    decl_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    next_cycle();
    next_cycle();
    tests_run++;
    if (decl_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_ready: got %b want 1", decl_ready);
    end
    tests_run++;
    if ({color_ld_en, visited_ld_en, elem_done} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL reset_strobes: got %b want 000", {color_ld_en, visited_ld_en, elem_done});
    end
    tests_run++;
    if (applied_cnt !== 8'd0 || color_data !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_cnt_data: got cnt %0d data %h want 0 0", applied_cnt, color_data);
    end
    tests_run++;
    if ({res_is_ident, res_for_visited} !== 2'b00 || res_ident !== 10'd0 || res_rgb !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_res: got %b %b %h %h want all 0", res_is_ident, res_for_visited, res_ident, res_rgb);
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      tests_run++;
      if ({color_ld_en, visited_ld_en, elem_done} !== 3'b000 || decl_ready !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL post_reset_idle: got strobes %b ready %b want 000 1",
                 {color_ld_en, visited_ld_en, elem_done}, decl_ready);
      end
    end
  endtask

  task automatic test_single();
    push_one(make_decl(1'b1, RED_ID, $urandom, 1'b1, 1'b1, 1'b1));
    tests_run++;
    if ({color_ld_en, visited_ld_en} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL single_t1_quiet: got %b want 00", {color_ld_en, visited_ld_en});
    end
    next_cycle();
    tests_run++;
    if ({color_ld_en, visited_ld_en} !== 2'b10 || color_data !== 32'hFF0000FF || res_for_visited !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_reg_write: got en %b data %h fv %b want 10 ff0000ff 0",
               {color_ld_en, visited_ld_en}, color_data, res_for_visited);
    end
    tests_run++;
    if (res_is_ident !== 1'b1 || res_ident !== RED_ID) begin
      tests_failed++;
      $display("[TB] FAIL single_res_operands: got %b %0d want 1 %0d", res_is_ident, res_ident, RED_ID);
    end
    next_cycle();
    tests_run++;
    if ({color_ld_en, visited_ld_en} !== 2'b01 || color_data !== 32'hFF0000FF || res_for_visited !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL single_vis_write: got en %b data %h fv %b want 01 ff0000ff 1",
               {color_ld_en, visited_ld_en}, color_data, res_for_visited);
    end
    next_cycle();
    tests_run++;
    if (elem_done !== 1'b1 || applied_cnt !== 8'd2) begin
      tests_failed++;
      $display("[TB] FAIL single_done: got done %b cnt %0d want 1 2", elem_done, applied_cnt);
    end
    next_cycle();
    tests_run++;
    if (elem_done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_done_pulse: got %b want 0", elem_done);
    end
  endtask

  task automatic test_currentcolor();
    logic [31:0] want;
    for (int k = 0; k < 2; k++) begin
      parent_color_isvalid = k[0];
      parent_color         = (k == 0) ? 32'hDEADBEEF : 32'h112233FF;
      parent_invalid_color = (k == 0) ? 32'h00000000 : 32'hCAFEF00D;
      want                 = (k == 0) ? 32'h00000000 : 32'h112233FF;
      push_one(make_decl(1'b1, CURRENTCOLOR_ID, $urandom, 1'b1, 1'b1, 1'b1));
      next_cycle();
      tests_run++;
      if (color_ld_en !== 1'b1 || color_data !== want) begin
        tests_failed++;
        $display("[TB] FAIL currentcolor_reg_%0d: got en %b data %h want 1 %h", k, color_ld_en, color_data, want);
      end
      next_cycle();
      tests_run++;
      if (visited_ld_en !== 1'b1 || color_data !== want) begin
        tests_failed++;
        $display("[TB] FAIL currentcolor_vis_%0d: got en %b data %h want 1 %h", k, visited_ld_en, color_data, want);
      end
      next_cycle();
      tests_run++;
      if (elem_done !== 1'b1 || applied_cnt !== 8'd2) begin
        tests_failed++;
        $display("[TB] FAIL currentcolor_done_%0d: got %b cnt %0d want 1 2", k, elem_done, applied_cnt);
      end
      next_cycle();
    end
  endtask

  task automatic test_noflag();
    push_one(make_decl(1'b0, 10'd0, $urandom, 1'b0, 1'b0, 1'b1));
    tests_run++;
    if ({color_ld_en, visited_ld_en, elem_done} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL noflag_idle: got %b want 000", {color_ld_en, visited_ld_en, elem_done});
    end
    next_cycle();
    tests_run++;
    if (elem_done !== 1'b1 || applied_cnt !== 8'd0 || {color_ld_en, visited_ld_en} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL noflag_done: got done %b cnt %0d en %b want 1 0 00",
               elem_done, applied_cnt, {color_ld_en, visited_ld_en});
    end
    next_cycle();
    tests_run++;
    if (elem_done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL noflag_after: got %b want 0", elem_done);
    end
  endtask

  task automatic test_fifo_full();
    logic [31:0] rgbs [5];
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rgbs[i] = $urandom;
      drive_decl(make_decl(1'b0, 10'd0, rgbs[i], 1'b1, 1'b0, (i == 3)));
      tests_run++;
      if (decl_ready !== (i < 4)) begin
        tests_failed++;
        $display("[TB] FAIL full_ready_%0d: got %b want %b", i, decl_ready, (i < 4));
      end
      next_cycle();
    end
    decl_valid = 1'b0;
    hold = 1'b0;
    #1;
    for (int j = 0; j < 4; j++) begin
      next_cycle();
      tests_run++;
      if (color_ld_en !== 1'b1 || color_data !== rgbs[j]) begin
        tests_failed++;
        $display("[TB] FAIL drain_write_%0d: got en %b data %h want 1 %h", j, color_ld_en, color_data, rgbs[j]);
      end
      next_cycle();
      if (j < 3) begin
        tests_run++;
        if ({color_ld_en, visited_ld_en, elem_done} !== 3'b000) begin
          tests_failed++;
          $display("[TB] FAIL drain_bubble_%0d: got %b want 000", j, {color_ld_en, visited_ld_en, elem_done});
        end
      end
    end
    tests_run++;
    if (elem_done !== 1'b1 || applied_cnt !== 8'd4) begin
      tests_failed++;
      $display("[TB] FAIL drain_done: got %b cnt %0d want 1 4", elem_done, applied_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      tests_run++;
      if ({color_ld_en, visited_ld_en, elem_done} !== 3'b000) begin
        tests_failed++;
        $display("[TB] FAIL fifth_rejected: got %b want 000", {color_ld_en, visited_ld_en, elem_done});
      end
    end
  endtask

  task automatic test_hold_reg();
    logic [31:0] rgb;
    rgb = $urandom;
    push_one(make_decl(1'b0, 10'd0, rgb, 1'b1, 1'b0, 1'b1));
    next_cycle();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (color_ld_en !== 1'b0 || elem_done !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL hold_stall_%0d: got en %b done %b want 0 0", i, color_ld_en, elem_done);
      end
      next_cycle();
    end
    hold = 1'b0;
    #1;
    tests_run++;
    if (color_ld_en !== 1'b1 || color_data !== rgb) begin
      tests_failed++;
      $display("[TB] FAIL hold_release_write: got en %b data %h want 1 %h", color_ld_en, color_data, rgb);
    end
    next_cycle();
    tests_run++;
    if (color_ld_en !== 1'b0 || elem_done !== 1'b1 || applied_cnt !== 8'd1) begin
      tests_failed++;
      $display("[TB] FAIL hold_done: got en %b done %b cnt %0d want 0 1 1", color_ld_en, elem_done, applied_cnt);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rgb;
    drive_decl(make_decl(1'b0, 10'd0, $urandom, 1'b1, 1'b1, 1'b1));
    next_cycle();
    drive_decl(make_decl(1'b0, 10'd0, $urandom, 1'b0, 1'b0, 1'b1));
    next_cycle();
    decl_valid = 1'b0;
    tests_run++;
    if (color_ld_en !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midreset_first_write: got %b want 1", color_ld_en);
    end
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    #1;
    tests_run++;
    if (decl_ready !== 1'b1 || applied_cnt !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_state: got ready %b cnt %0d want 1 0", decl_ready, applied_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if ({color_ld_en, visited_ld_en, elem_done} !== 3'b000) begin
        tests_failed++;
        $display("[TB] FAIL midreset_quiet_%0d: got %b want 000", i, {color_ld_en, visited_ld_en, elem_done});
      end
      next_cycle();
    end
    rgb = $urandom;
    push_one(make_decl(1'b0, 10'd0, rgb, 1'b1, 1'b0, 1'b1));
    next_cycle();
    tests_run++;
    if (color_ld_en !== 1'b1 || color_data !== rgb) begin
      tests_failed++;
      $display("[TB] FAIL midreset_next_write: got en %b data %h want 1 %h", color_ld_en, color_data, rgb);
    end
    next_cycle();
    tests_run++;
    if (elem_done !== 1'b1 || applied_cnt !== 8'd1) begin
      tests_failed++;
      $display("[TB] FAIL midreset_next_done: got %b cnt %0d want 1 1", elem_done, applied_cnt);
    end
    next_cycle();
  endtask

  task automatic test_random();
    tb_decl_t d;
    ev_t      e;
    logic [1:0] obs_kind;
    int offered = 0;
    int cycles  = 0;
    int obs_n;
    ev_q.delete();
    model_cnt            = 0;
    parent_color         = $urandom;
    parent_invalid_color = $urandom;
    parent_color_isvalid = 1'($urandom_range(0, 1));
    while ((offered < RANDOM_DECLS || ev_q.size() > 0) && cycles < 4000) begin
      @(posedge clk);
      #1;
      hold = ($urandom_range(0, 4) == 0);
      if (offered < RANDOM_DECLS && $urandom_range(0, 2) != 0) begin
        d = make_decl(1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0) ? CURRENTCOLOR_ID : 10'($urandom),
                      $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      (offered == RANDOM_DECLS - 1) || ($urandom_range(0, 3) == 0));
        drive_decl(d);
      end else begin
        decl_valid = 1'b0;
      end
      #4;
      obs_n = int'(color_ld_en) + int'(visited_ld_en) + int'(elem_done);
      if (hold) begin
        tests_run++;
        if (obs_n != 0) begin
          tests_failed++;
          $display("[TB] FAIL rand_hold_gate: got strobes %b want 000", {color_ld_en, visited_ld_en, elem_done});
        end
      end else if (obs_n > 0) begin
        tests_run++;
        obs_kind = color_ld_en ? EV_COLOR : (visited_ld_en ? EV_VISITED : EV_DONE);
        if (obs_n > 1) begin
          tests_failed++;
          $display("[TB] FAIL rand_multi_strobe: got %b want one-hot", {color_ld_en, visited_ld_en, elem_done});
        end else if (ev_q.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL rand_unexpected: got kind %0d want none", obs_kind);
        end else begin
          e = ev_q.pop_front();
          if (obs_kind !== e.kind || (e.kind != EV_DONE && color_data !== e.data)
              || (e.kind == EV_DONE && applied_cnt !== e.cnt)) begin
            tests_failed++;
            $display("[TB] FAIL rand_event: got kind %0d data %h cnt %0d want kind %0d data %h cnt %0d",
                     obs_kind, color_data, applied_cnt, e.kind, e.data, e.cnt);
          end
        end
      end
      if (decl_valid && decl_ready) begin
        model_add(d);
        offered++;
      end
      cycles++;
    end
    @(posedge clk);
    #1;
    decl_valid = 1'b0;
    hold = 1'b0;
    tests_run++;
    if (offered != RANDOM_DECLS || ev_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL rand_drain_timeout: got offered %0d pending %0d want %0d 0",
               offered, ev_q.size(), RANDOM_DECLS);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset                = 1'b0;
    hold                 = 1'b0;
    decl_valid           = 1'b0;
    decl_is_ident        = 1'b0;
    decl_ident           = '0;
    decl_rgb             = '0;
    decl_regular         = 1'b0;
    decl_visited         = 1'b0;
    decl_last            = 1'b0;
    css_currentcolor     = CURRENTCOLOR_ID;
    parent_color         = '0;
    parent_color_isvalid = 1'b0;
    parent_invalid_color = '0;
    test_reset();
    test_single();
    test_currentcolor();
    test_noflag();
    test_fifo_full();
    test_hold_reg();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/color_apply_seq.md
# color_apply_seq

Sequencer that feeds queued color declarations into the shared color-resolution datapath for one element at a time, issuing the regular-style write and the visited-link-style write as separate passes through a single resolver instance. It buffers incoming declarations in a small FIFO and resolves the currentcolor-inherit case locally from the parent color. It drives the load enables of the inherited color and visited-link color registers, and reports element completion with a count of applied writes.

## Interface
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- decl_valid  in  1  declaration offered.
- decl_ready  out  1  FIFO not full.
- decl_is_ident  in  1  primitive unit type is CSS_IDENT (else CSS_RGBCOLOR).
- decl_ident  in  10  CSSValue ID.
- decl_rgb  in  32  RGBA value.
- decl_regular  in  1  apply to regular style.
- decl_visited  in  1  apply to visited-link style.
- decl_last  in  1  final declaration of the element.
- css_currentcolor  in  10  CSSValueCurrentcolor ID.
- parent_color  in  32  parent style color.
- parent_color_isvalid  in  1  parent color valid.
- parent_invalid_color  in  32  parent invalidColor().
- res_is_ident, res_ident, res_rgb, res_for_visited  out  1/10/32/1  operands to the shared resolver; res_for_visited is 1 only in VIS.
- res_color  in  32  resolver result, combinational, same cycle.
- hold  in  1  style write port busy; freezes the sequencer.
- color_ld_en  out  1  write inherited color.
- visited_ld_en  out  1  write inherited visited-link color.
- color_data  out  32  write data, shared by both enables.
- elem_done  out  1  one-cycle pulse at element end.
- applied_cnt  out  8  writes applied for the element; valid while elem_done=1.

## Operation
- FIFO: a push occurs when decl_valid and decl_ready are both 1. decl_ready is the inverse of full. A push and pop in the same cycle are legal when the FIFO is not full. When the FIFO is full, decl_ready is 0 even in a popping cycle.
- FSM states: IDLE, REG, VIS, DONE.
- IDLE, FIFO empty: stay in IDLE.
- IDLE, head has decl_regular=1: go to REG.
- IDLE, head has decl_regular=0 and decl_visited=1: go to VIS.
- IDLE, head has neither flag: pop the head in this cycle. Then go to DONE if that head had decl_last=1, otherwise stay in IDLE.
- REG: drive the resolver from the head entry with res_for_visited=0 and assert color_ld_en. Then go to VIS if the head has decl_visited=1. Otherwise pop and go to DONE if decl_last=1, else IDLE.
- VIS: drive the resolver with res_for_visited=1 and assert visited_ld_en. Pop the head, then go to DONE if decl_last=1, else IDLE.
- DONE: assert elem_done and present applied_cnt, then go to IDLE. The counter clears on leaving DONE.
- Inherit rule: if decl_is_ident=1 and decl_ident equals css_currentcolor, color_data is parent_color when parent_color_isvalid=1, else parent_invalid_color. In all other cases color_data is res_color. The rule applies to both passes.
- applied_cnt: increments by 1 on each cycle where color_ld_en or visited_ld_en is 1. Saturates at 255.
- hold=1: the FSM state, FIFO pointers and counter are frozen. color_ld_en, visited_ld_en and elem_done are forced to 0. FIFO pushes are still accepted.

## Timing
- Reset values: FSM in IDLE, FIFO empty, counter 0. decl_ready=1 and every other output is 0, including res_* and color_data.
- A declaration accepted in cycle t appears at the FIFO head in t+1. IDLE decodes it in t+1, and the first write enable is asserted in t+2.
- A REG+VIS entry uses two consecutive write cycles. The sequencer returns to IDLE for a one-cycle bubble between entries; DONE adds one further cycle.
- Write enables are combinational from the state and hold. color_data is combinational and valid only while an enable is 1.
- Reset asserted mid-element discards all FIFO contents and the partial count. elem_done is not pulsed.

## Structure
- Shared package: FSM state encoding (2 bits) and the FIFO entry type {is_ident, ident[9:0], rgb[31:0], regular, visited, last} = 46 bits.
- Sub-module: decl_fifo (DEPTH×46, registered pointers, full/empty flags). FSM, inherit mux and counter sit in the top level.

## Test plan
- Single entry: ident=Red, regular=1, visited=1, last=1, res_color=0xFF0000FF.
  - color_ld_en at t+2 and visited_ld_en at t+3, both with color_data=0xFF0000FF.
  - elem_done at t+4 with applied_cnt=2.
- Currentcolor inherit: currentcolor with parent_color_isvalid=0 and parent_invalid_color=0x00000000 → both writes carry 0x00000000. Repeat with isvalid=1 and parent_color=0x112233FF → both writes carry 0x112233FF.
- No-flag entry with last=1 → popped in IDLE, no enables, elem_done in the next cycle with applied_cnt=0.
- FIFO full: push 5 entries back-to-back with hold=1 → decl_ready drops after the 4th push. Release hold → 4 entries drain in order, with a bubble between each.
- hold asserted during REG for 3 cycles → color_ld_en stays 0 for those 3 cycles, then asserts once. applied_cnt is unaffected by the stall.
- Reset mid-element: after 1 write, assert reset for 1 cycle → FIFO empty, decl_ready=1, no elem_done pulse. The next element reports a count starting from 0.
